// File: rtl/cpld_ram_banker.sv
// CPC RAM-expansion banker: decodes 0x7Fxx bank writes and drives the external
// SRAM chip selects, high address bits, timed write strobe and RAMDIS.
// Optional build macro: M4_COMPAT_EN (adds o_wr_b_oe for M4-card write forcing).
`timescale 1ns/1ps
module cpld_ram_banker #(
  parameter int unsigned EXT_BITS = 1,
  parameter int unsigned NUM_CS   = 2,
  localparam int unsigned ADR_IO_W = (EXT_BITS == 0) ? 1 : EXT_BITS
) (
  input  logic                clk,
  input  logic                reset_b_w,
  input  logic                i_rfsh_b,
  input  logic                i_mreq_b,
  input  logic                i_iorq_b,
  input  logic                i_rd_b,
  input  logic                i_wr_b,
  input  logic                i_adr15,
  input  logic                i_adr14,
  input  logic [ADR_IO_W-1:0] i_adr_io,
  input  logic [7:0]          i_data,
  input  logic                i_overdrive,
  input  logic                i_cardsel,
  output logic [NUM_CS-1:0]   o_ramcs_b,
  output logic [4:0]          o_ramadrhi,
  output logic                o_ramwe_b,
  output logic                o_ramoe_b,
  output logic                o_ramdis,
  output logic                o_adr15_oe
`ifdef M4_COMPAT_EN
  ,
  output logic                o_wr_b_oe
`endif
);

  localparam int unsigned CHIP_W = ADR_IO_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_SETUP  = 2'd1,
    ST_WR_ACTIVE = 2'd2
  } wr_state_e;

  logic [2:0]        r_mode;
  logic [2:0]        r_block;
  logic [CHIP_W-1:0] r_chip;
  logic              r_adr15_q;
  wr_state_e         r_state;
  wr_state_e         w_state_nxt;

  logic              w_cfg_sel;
  logic              w_ext_hit;
  logic              w_sel;
  logic [1:0]        w_page;
  logic [1:0]        w_page_m3;
  logic [1:0]        w_p;
  logic              w_ramwe_b;
  logic              w_wr_b_oe;
  logic [NUM_CS-1:0] w_ramcs_b;

  // Bank register write: I/O write with A15 low and data[7:6] == 2'b11
  assign w_cfg_sel = !i_iorq_b && !i_wr_b && !i_adr15 && (i_data[7:6] == 2'b11);

  // Capture mode/block/chip on the falling clock edge
  always_ff @(negedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      r_mode  <= 3'd0;
      r_block <= 3'd0;
      r_chip  <= '0;
    end else if (w_cfg_sel) begin
      r_mode  <= i_data[2:0];
      r_block <= i_data[5:3];
      r_chip  <= (EXT_BITS == 0) ? '0 : ~i_adr_io;
    end
  end

  // Hold A15 from before MREQ so a forced bus A15 cannot disturb mode-3 decode
  always_ff @(negedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      r_adr15_q <= 1'b0;
    end else if (i_mreq_b) begin
      r_adr15_q <= i_adr15;
    end
  end

  // Mode map: decide whether the current page hits external SRAM and which page
  always_comb begin
    w_page    = {i_adr15, i_adr14};
    w_page_m3 = {r_adr15_q, i_adr14};
    w_ext_hit = 1'b0;
    w_p       = w_page;
    case (r_mode)
      3'd0: begin
        w_ext_hit = 1'b0;
      end
      3'd1: begin
        if (w_page == 2'd3) begin
          w_ext_hit = 1'b1;
          w_p       = 2'd3;
        end
      end
      3'd2: begin
        w_ext_hit = 1'b1;
      end
      3'd3: begin
        // page 1 lands on the page-3 bank only when A15 is being forced high
        w_p = 2'd3;
        if ((w_page_m3 == 2'd3) || ((w_page_m3 == 2'd1) && i_overdrive)) begin
          w_ext_hit = 1'b1;
        end
      end
      default: begin
        if (w_page == 2'd1) begin
          w_ext_hit = 1'b1;
          w_p       = r_mode[1:0];
        end
      end
    endcase
  end

  // Chip select is qualified by a genuine memory cycle (no I/O, no refresh)
  assign w_sel = w_ext_hit && i_cardsel && !i_mreq_b && i_rfsh_b && i_iorq_b;

  // One-hot-low chip select for the chip chosen by the last bank write
  always_comb begin
    w_ramcs_b = '1;
    if (w_sel) begin
      w_ramcs_b[r_chip] = 1'b0;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge reset_b_w) begin
    if (!reset_b_w) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM next state and write-strobe outputs
  always_comb begin
    w_state_nxt = r_state;
    w_ramwe_b   = 1'b1;
    w_wr_b_oe   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_mreq_b && i_rd_b && i_rfsh_b) begin
          w_state_nxt = ST_WR_SETUP;
        end
      end
      ST_WR_SETUP: begin
        w_state_nxt = ST_WR_ACTIVE;
        w_wr_b_oe   = i_overdrive && w_ext_hit;
      end
      ST_WR_ACTIVE: begin
        w_ramwe_b = !(!i_wr_b && w_ext_hit && i_cardsel);
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_mreq_b) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign o_ramcs_b  = w_ramcs_b;
  assign o_ramadrhi = {r_block, w_p};
  assign o_ramwe_b  = w_ramwe_b;
  assign o_ramoe_b  = i_rd_b || (&w_ramcs_b);
  assign o_ramdis   = w_ext_hit && i_cardsel;
  assign o_adr15_oe = i_overdrive && (r_mode == 3'd3) && i_adr14 && !i_mreq_b;

`ifdef M4_COMPAT_EN
  assign o_wr_b_oe = w_wr_b_oe;
`else
  logic w_unused;
  assign w_unused = w_wr_b_oe;
`endif

endmodule

// File: tb/tb_cpld_ram_banker.sv
// Self-checking bench for cpld_ram_banker: fixed vector table, hand-written
// multi-cycle sequences and randomized cycles against a bank-map model.
`timescale 1ns/1ps
module tb_cpld_ram_banker;

  localparam int unsigned EXT_BITS = 1;
  localparam int unsigned NUM_CS   = 2;

  logic                clk = 1'b0;
  logic                reset_b_w = 1'b1;
  logic                rfsh_b = 1'b1;
  logic                mreq_b = 1'b1;
  logic                iorq_b = 1'b1;
  logic                rd_b = 1'b1;
  logic                wr_b = 1'b1;
  logic                adr15 = 1'b0;
  logic                adr14 = 1'b0;
  logic [EXT_BITS-1:0] adr_io = '0;
  logic [7:0]          data = 8'h00;
  logic                overdrive = 1'b0;
  logic                cardsel = 1'b1;
  logic [NUM_CS-1:0]   ramcs_b;
  logic [4:0]          ramadrhi;
  logic                ramwe_b;
  logic                ramoe_b;
  logic                ramdis;
  logic                adr15_oe;
`ifdef M4_COMPAT_EN
  logic                wr_b_oe;
`endif

  cpld_ram_banker #(.EXT_BITS(EXT_BITS), .NUM_CS(NUM_CS)) dut (
    .clk        (clk),
    .reset_b_w  (reset_b_w),
    .i_rfsh_b   (rfsh_b),
    .i_mreq_b   (mreq_b),
    .i_iorq_b   (iorq_b),
    .i_rd_b     (rd_b),
    .i_wr_b     (wr_b),
    .i_adr15    (adr15),
    .i_adr14    (adr14),
    .i_adr_io   (adr_io),
    .i_data     (data),
    .i_overdrive(overdrive),
    .i_cardsel  (cardsel),
    .o_ramcs_b  (ramcs_b),
    .o_ramadrhi (ramadrhi),
    .o_ramwe_b  (ramwe_b),
    .o_ramoe_b  (ramoe_b),
    .o_ramdis   (ramdis),
    .o_adr15_oe (adr15_oe)
`ifdef M4_COMPAT_EN
    ,
    .o_wr_b_oe  (wr_b_oe)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference bank map per mode and page: -1 internal, -2 page-3 bank only under overdrive
  int bank_tbl [8][4] = '{
    '{-1, -1, -1, -1},
    '{-1, -1, -1,  3},
    '{ 0,  1,  2,  3},
    '{-1, -2, -1,  3},
    '{-1,  0, -1, -1},
    '{-1,  1, -1, -1},
    '{-1,  2, -1, -1},
    '{-1,  3, -1, -1}
  };

  int m_mode  = 0;
  int m_block = 0;
  int m_chip  = 0;

  typedef struct {
    logic [15:0] port;
    logic [7:0]  cfg;
    logic        od;
    logic        cs_en;
    logic [15:0] addr;
    logic [1:0]  e_cs;
    logic [4:0]  e_hi;
    logic        e_dis;
    logic        e_oe15;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bank_of(input int mode, input logic [15:0] a, input logic od);
    int b;
    b = bank_tbl[mode][int'(a[15:14])];
    if (b == -2) b = od ? 3 : -1;
    return b;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_block = 0;
    m_chip  = 0;
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] d);
    @(posedge clk); #1;
    adr15  = port[15];
    adr14  = port[14];
    adr_io = port[8 +: EXT_BITS];
    data   = d;
    iorq_b = 1'b0;
    wr_b   = 1'b0;
    @(negedge clk); #1;
    iorq_b = 1'b1;
    wr_b   = 1'b1;
    if (!port[15] && d[7:6] == 2'b11) begin
      m_mode  = int'(d[2:0]);
      m_block = int'(d[5:3]);
      m_chip  = (NUM_CS - 1) - (int'(port[15:8]) % NUM_CS);
    end
  endtask

  task automatic mem_begin(input logic [15:0] a, input bit is_wr);
    @(posedge clk); #1;
    adr15  = a[15];
    adr14  = a[14];
    adr_io = a[8 +: EXT_BITS];
    data   = a[7:0];
    @(negedge clk); #1;
    mreq_b = 1'b0;
    if (is_wr) wr_b = 1'b0;
    else       rd_b = 1'b0;
    #1;
  endtask

  task automatic mem_end();
    @(negedge clk); #1;
    mreq_b = 1'b1;
    rd_b   = 1'b1;
    wr_b   = 1'b1;
    iorq_b = 1'b1;
    rfsh_b = 1'b1;
  endtask

  task automatic check_decode(input string tag, input logic [15:0] a, input bit is_rd);
    int         b;
    bit         sel;
    logic [1:0] e_cs;
    b    = bank_of(m_mode, a, overdrive);
    sel  = (b >= 0) && cardsel;
    e_cs = sel ? 2'(~(1 << m_chip)) : 2'b11;
    chk({tag, " ramcs_b"}, 32'(ramcs_b), 32'(e_cs));
    if (b >= 0) chk({tag, " ramadrhi"}, 32'(ramadrhi), 32'(m_block * 4 + b));
    chk({tag, " ramdis"}, 32'(ramdis), 32'(sel));
    chk({tag, " adr15_oe"}, 32'(adr15_oe), 32'(overdrive && m_mode == 3 && a[14]));
    chk({tag, " ramoe_b"}, 32'(ramoe_b), 32'(is_rd ? !sel : 1'b1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{16'h7E00, 8'hC4, 1'b0, 1'b1, 16'h4123, 2'b01, 5'b00000, 1'b1, 1'b0};
    vt[1]  = '{16'h7F00, 8'hFA, 1'b0, 1'b1, 16'h8000, 2'b10, 5'b11110, 1'b1, 1'b0};
    vt[2]  = '{16'h7F00, 8'hFA, 1'b0, 1'b1, 16'h0010, 2'b10, 5'b11100, 1'b1, 1'b0};
    vt[3]  = '{16'h7F00, 8'hC1, 1'b0, 1'b1, 16'hC000, 2'b10, 5'b00011, 1'b1, 1'b0};
    vt[4]  = '{16'h7F00, 8'hC1, 1'b0, 1'b1, 16'h4000, 2'b11, 5'b00000, 1'b0, 1'b0};
    vt[5]  = '{16'h7F00, 8'hC3, 1'b1, 1'b1, 16'h4000, 2'b10, 5'b00011, 1'b1, 1'b1};
    vt[6]  = '{16'h7F00, 8'hC3, 1'b0, 1'b1, 16'h4000, 2'b11, 5'b00000, 1'b0, 1'b0};
    vt[7]  = '{16'h7F00, 8'hC3, 1'b0, 1'b1, 16'hC000, 2'b10, 5'b00011, 1'b1, 1'b0};
    vt[8]  = '{16'h7E00, 8'hEF, 1'b0, 1'b1, 16'h7FFF, 2'b01, 5'b10111, 1'b1, 1'b0};
    vt[9]  = '{16'h7E00, 8'hEF, 1'b0, 1'b0, 16'h7FFF, 2'b11, 5'b00000, 1'b0, 1'b0};
    vt[10] = '{16'h7F00, 8'hC0, 1'b0, 1'b1, 16'hC000, 2'b11, 5'b00000, 1'b0, 1'b0};
    vt[11] = '{16'h7E00, 8'hD5, 1'b0, 1'b1, 16'h4000, 2'b01, 5'b01001, 1'b1, 1'b0};
    vt[12] = '{16'h7F00, 8'h82, 1'b0, 1'b1, 16'h4000, 2'b01, 5'b01001, 1'b1, 1'b0};
    vt[13] = '{16'hFF00, 8'hC0, 1'b0, 1'b1, 16'h4000, 2'b01, 5'b01001, 1'b1, 1'b0};

    // Reset and check idle state
    #1 reset_b_w = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_b_w = 1'b1;
    mem_begin(16'h4000, 1'b0);
    chk("reset ramcs_b", 32'(ramcs_b), 32'(2'b11));
    chk("reset ramdis", 32'(ramdis), 32'(1'b0));
    chk("reset adr15_oe", 32'(adr15_oe), 32'(1'b0));
    chk("reset ramwe_b", 32'(ramwe_b), 32'(1'b1));
    chk("reset ramoe_b", 32'(ramoe_b), 32'(1'b1));
    mem_end();

    // Fixed vector table
    for (int i = 0; i < 14; i++) begin
      io_write(vt[i].port, vt[i].cfg);
      overdrive = vt[i].od;
      cardsel   = vt[i].cs_en;
      mem_begin(vt[i].addr, 1'b0);
      chk($sformatf("vec%0d ramcs_b", i), 32'(ramcs_b), 32'(vt[i].e_cs));
      chk($sformatf("vec%0d ramdis", i), 32'(ramdis), 32'(vt[i].e_dis));
      chk($sformatf("vec%0d adr15_oe", i), 32'(adr15_oe), 32'(vt[i].e_oe15));
      chk($sformatf("vec%0d ramoe_b", i), 32'(ramoe_b), 32'(vt[i].e_cs == 2'b11));
      if (vt[i].e_dis) chk($sformatf("vec%0d ramadrhi", i), 32'(ramadrhi), 32'(vt[i].e_hi));
      mem_end();
    end
    overdrive = 1'b0;
    cardsel   = 1'b1;

    // Write strobe timing: low from the 2nd rising edge, released with wr_b
    io_write(16'h7E00, 8'hC4);
    mem_begin(16'h4123, 1'b1);
    chk("wr t0 ramwe_b", 32'(ramwe_b), 32'(1'b1));
    chk("wr t0 ramcs_b", 32'(ramcs_b), 32'(2'b01));
    @(posedge clk); #1;
    chk("wr setup ramwe_b", 32'(ramwe_b), 32'(1'b1));
    @(posedge clk); #1;
    chk("wr active ramwe_b", 32'(ramwe_b), 32'(1'b0));
    wr_b = 1'b1; #1;
    chk("wr release ramwe_b", 32'(ramwe_b), 32'(1'b1));
    mem_end();

    // Reset in the middle of a write
    mem_begin(16'h4123, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("midrst pre ramwe_b", 32'(ramwe_b), 32'(1'b0));
    reset_b_w = 1'b0;
    model_reset();
    #1;
    chk("midrst ramwe_b", 32'(ramwe_b), 32'(1'b1));
    chk("midrst ramcs_b", 32'(ramcs_b), 32'(2'b11));
    mem_end();
    #2 reset_b_w = 1'b1;
    mem_begin(16'h4123, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("postrst ramwe_b", 32'(ramwe_b), 32'(1'b1));
    chk("postrst ramcs_b", 32'(ramcs_b), 32'(2'b11));
    chk("postrst ramdis", 32'(ramdis), 32'(1'b0));
    mem_end();

    // MREQ and IORQ both low: no select
    io_write(16'h7F00, 8'hFA);
    mem_begin(16'h8000, 1'b0);
    iorq_b = 1'b0; #1;
    chk("iorq+mreq ramcs_b", 32'(ramcs_b), 32'(2'b11));
    chk("iorq+mreq ramoe_b", 32'(ramoe_b), 32'(1'b1));
    mem_end();

    // Refresh cycle never selects or writes
    @(posedge clk); #1;
    adr15 = 1'b0; adr14 = 1'b0;
    @(negedge clk); #1;
    mreq_b = 1'b0; rfsh_b = 1'b0; wr_b = 1'b0; #1;
    chk("rfsh ramcs_b", 32'(ramcs_b), 32'(2'b11));
    repeat (2) @(posedge clk);
    #1 chk("rfsh ramwe_b", 32'(ramwe_b), 32'(1'b1));
    mem_end();

    // Leaving mode 3 takes effect on the next memory cycle
    overdrive = 1'b1;
    io_write(16'h7F00, 8'hC3);
    mem_begin(16'h4000, 1'b0);
    chk("m3 adr15_oe", 32'(adr15_oe), 32'(1'b1));
    chk("m3 ramadrhi", 32'(ramadrhi), 32'(5'b00011));
    mem_end();
    io_write(16'h7F00, 8'hC0);
    mem_begin(16'h4000, 1'b0);
    chk("m3exit adr15_oe", 32'(adr15_oe), 32'(1'b0));
    chk("m3exit ramcs_b", 32'(ramcs_b), 32'(2'b11));
    mem_end();

`ifdef M4_COMPAT_EN
    // Forced bus write for one setup cycle only
    io_write(16'h7E00, 8'hC4);
    mem_begin(16'h4123, 1'b1);
    chk("m4 t0 wr_b_oe", 32'(wr_b_oe), 32'(1'b0));
    @(posedge clk); #1;
    chk("m4 setup wr_b_oe", 32'(wr_b_oe), 32'(1'b1));
    chk("m4 setup ramwe_b", 32'(ramwe_b), 32'(1'b1));
    @(posedge clk); #1;
    chk("m4 active wr_b_oe", 32'(wr_b_oe), 32'(1'b0));
    chk("m4 active ramwe_b", 32'(ramwe_b), 32'(1'b0));
    mem_end();
`endif
    overdrive = 1'b0;

    // Randomized configuration writes and memory cycles against the model
    for (int n = 0; n < 300; n++) begin
      logic [15:0] port;
      logic [7:0]  d;
      logic [15:0] a;
      bit          is_wr;
      int          b;
      port = {($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 6'b111111, 1'($urandom), 8'($urandom)};
      d    = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[7:6] = 2'b11;
      io_write(port, d);
      overdrive = 1'($urandom);
      cardsel   = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      is_wr     = 1'($urandom);
      mem_begin(a, is_wr);
      check_decode($sformatf("rnd%0d", n), a, !is_wr);
      if (is_wr) begin
        b = bank_of(m_mode, a, overdrive);
        @(posedge clk); #1;
        chk($sformatf("rnd%0d setup ramwe_b", n), 32'(ramwe_b), 32'(1'b1));
        @(posedge clk); #1;
        chk($sformatf("rnd%0d active ramwe_b", n), 32'(ramwe_b), 32'(!((b >= 0) && cardsel)));
      end
      mem_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
